ifetch_sram_arbiter: RTL and testbench
======================================

// Module: ifetch_sram_arbiter
// PURPOSE
//  Responder side of the fetcher memory handshake (addr/rd_en/ack). One instance per SRAM bank.
//  Arbitrates the instruction fetcher (read-only) and the execution data port (read/write) onto
//  one asynchronous SRAM with programmable wait states.
//  Returns read data and a one-cycle ack to the granted requester.
// PARAMETERS
//  SRAM_ADDR_SIZE  15  address width, {channel[2:0], local_addr[11:0]}
//  DATA_SIZE       8   SRAM data width
//  WAIT_STATES     1   extra SRAM access cycles beyond the first (0..7)
// PORTS
//  clk          in   1     clock, all activity on posedge
//  reset        in   1     synchronous, active-high
//  if_addr      in   SRAM_ADDR_SIZE  fetcher address
//  if_rd_en     in   1     fetcher read request, held until if_ack
//  if_ack       out  1     one-cycle pulse: if_d_out valid this cycle
//  if_d_out     out  DATA_SIZE  read data to fetcher (= rd_data)
//  dp_addr      in   SRAM_ADDR_SIZE  data port address
//  dp_rd_en     in   1     data port read request, held until dp_ack
//  dp_wr_en     in   1     data port write request, held until dp_ack
//  dp_d_in      in   DATA_SIZE  write data, held until dp_ack
//  dp_ack       out  1     one-cycle pulse: read data valid / write done
//  dp_d_out     out  DATA_SIZE  read data to data port (= rd_data)
//  sram_addr    out  SRAM_ADDR_SIZE  SRAM address
//  sram_d_out   out  DATA_SIZE  SRAM write data
//  sram_d_oe    out  1     high = drive sram_d_out onto the bus (external tristate)
//  sram_d_in    in   DATA_SIZE  SRAM read data
//  sram_ce_n    out  1     chip enable, active low
//  sram_oe_n    out  1     output enable, active low
//  sram_we_n    out  1     write enable, active low
// BEHAVIOUR
//  Reset values:
//   - if_ack = dp_ack = 0; rd_data = 0; sram_addr = 0; sram_d_oe = 0.
//   - sram_ce_n = sram_oe_n = sram_we_n = 1; state IDLE; last_grant = DP (fetcher wins first tie).
//  Reset mid-access: abort, return to IDLE next edge, all strobes inactive, no ack.
//  FSM states: IDLE -> ACCESS -> ACK -> IDLE.
//  IDLE:
//   - Request = if_rd_en | dp_rd_en | dp_wr_en.
//   - If any request: latch grant, addr, op and write data; sram_addr <= addr; ce_n <= 0.
//   - Read: oe_n <= 0. Write: sram_d_oe <= 1 and we_n <= 0. Load cnt <= WAIT_STATES; go to ACCESS.
//  Arbitration when both ports request: grant the port not in last_grant (round-robin).
//   - last_grant updates on every grant.
//  dp_rd_en & dp_wr_en both high: treated as a write.
//  ACCESS (WAIT_STATES+1 cycles):
//   - cnt decrements each cycle.
//   - At cnt==0: read ops capture rd_data <= sram_d_in; we_n <= 1 (write ends); oe_n <= 1; go to ACK.
//  ACK (1 cycle):
//   - Ack of the granted port = 1; sram_addr held.
//   - sram_d_oe deasserted, ce_n <= 1 on exit.
//   - No new request accepted in ACK, so a still-high rd_en is not re-serviced.
//  Latency: rd_en asserted before edge E0 -> ack high in cycle E0+WAIT_STATES+2.
//   - Repeat period is WAIT_STATES+3 cycles per access.
//  rd_data holds until the next read completes; writes do not alter it.
//  Request withdrawn mid-access: access completes and ack still pulses; requester must ignore it.
//  Address/data changes mid-access are not observed (latched in IDLE).
//  if_ack and dp_ack are never high in the same cycle.
// TESTING
//  1. Reset, then if_rd_en, addr 0x1005, SRAM model returns 0xA7, WAIT_STATES=1
//     -> if_ack=1 exactly 3 cycles after grant edge, if_d_out=0xA7, one pulse only.
//  2. dp_wr_en, addr 0x2010, data 0x5C
//     -> we_n low for 2 cycles, sram_d_oe high, dp_ack once; a following dp read of 0x2010 returns 0x5C.
//  3. if_rd_en and dp_rd_en asserted together and held for 4 accesses
//     -> grants alternate IF, DP, IF, DP; each ack carries its own address's data.
//  4. Fetcher holds if_rd_en high and increments addr after each ack (0x000..0x003)
//     -> 4 acks spaced 4 cycles apart, data matching each address, no duplicate read.
//  5. reset asserted during ACCESS of a write
//     -> next cycle ce_n = we_n = 1, sram_d_oe = 0, no dp_ack; the next request is serviced normally.
//  6. WAIT_STATES=0 and dp_rd_en & dp_wr_en both high
//     -> write performed, ack 2 cycles after grant edge, rd_data unchanged.

Source files
------------

// File: rtl/ifetch_sram_arbiter.sv
// Instruction-fetch / data-port arbiter for one asynchronous SRAM bank.
// One access at a time: IDLE latches the winner, ACCESS holds the strobes
// for WAIT_STATES+1 cycles, ACK pulses the granted port's ack for one cycle.
module ifetch_sram_arbiter #(
  parameter int SRAM_ADDR_SIZE = 15,
  parameter int DATA_SIZE      = 8,
  parameter int WAIT_STATES    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SRAM_ADDR_SIZE-1:0] if_addr,
  input  logic                      if_rd_en,
  output logic                      if_ack,
  output logic [DATA_SIZE-1:0]      if_d_out,
  input  logic [SRAM_ADDR_SIZE-1:0] dp_addr,
  input  logic                      dp_rd_en,
  input  logic                      dp_wr_en,
  input  logic [DATA_SIZE-1:0]      dp_d_in,
  output logic                      dp_ack,
  output logic [DATA_SIZE-1:0]      dp_d_out,
  output logic [SRAM_ADDR_SIZE-1:0] sram_addr,
  output logic [DATA_SIZE-1:0]      sram_d_out,
  output logic                      sram_d_oe,
  input  logic [DATA_SIZE-1:0]      sram_d_in,
  output logic                      sram_ce_n,
  output logic                      sram_oe_n,
  output logic                      sram_we_n
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t                    state, state_nxt;
  logic [2:0]                cnt, cnt_nxt;
  logic                      grant_dp, grant_dp_nxt;
  logic                      op_wr, op_wr_nxt;
  logic                      last_dp, last_dp_nxt;
  logic [DATA_SIZE-1:0]      rd_data, rd_data_nxt;
  logic [SRAM_ADDR_SIZE-1:0] sram_addr_nxt;
  logic [DATA_SIZE-1:0]      sram_d_out_nxt;
  logic                      sram_d_oe_nxt, ce_n_nxt, oe_n_nxt, we_n_nxt;
  logic                      if_req, dp_req, pick_dp, wr_req;

  // Next-state and next strobe values; everything defaults to hold.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    grant_dp_nxt   = grant_dp;
    op_wr_nxt      = op_wr;
    last_dp_nxt    = last_dp;
    rd_data_nxt    = rd_data;
    sram_addr_nxt  = sram_addr;
    sram_d_out_nxt = sram_d_out;
    sram_d_oe_nxt  = sram_d_oe;
    ce_n_nxt       = sram_ce_n;
    oe_n_nxt       = sram_oe_n;
    we_n_nxt       = sram_we_n;
    if_req         = if_rd_en;
    dp_req         = dp_rd_en | dp_wr_en;
    // Round-robin: on a tie the port that did not win last time goes next.
    pick_dp        = dp_req & (~if_req | ~last_dp);
    // A simultaneous read+write on the data port is treated as a write.
    wr_req         = pick_dp & dp_wr_en;
    case (state)
      IDLE: begin
        if (if_req | dp_req) begin
          grant_dp_nxt  = pick_dp;
          last_dp_nxt   = pick_dp;
          op_wr_nxt     = wr_req;
          sram_addr_nxt = pick_dp ? dp_addr : if_addr;
          ce_n_nxt      = 1'b0;
          if (wr_req) begin
            sram_d_out_nxt = dp_d_in;
            sram_d_oe_nxt  = 1'b1;
            we_n_nxt       = 1'b0;
          end else begin
            oe_n_nxt = 1'b0;
          end
          cnt_nxt   = 3'(WAIT_STATES);
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == 3'd0) begin
          if (!op_wr) rd_data_nxt = sram_d_in;
          we_n_nxt  = 1'b1;
          oe_n_nxt  = 1'b1;
          state_nxt = ACK;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      ACK: begin
        sram_d_oe_nxt = 1'b0;
        ce_n_nxt      = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state and strobes; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      last_dp   <= 1'b1;
      rd_data   <= '0;
      sram_addr <= '0;
      sram_d_oe <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      last_dp   <= last_dp_nxt;
      rd_data   <= rd_data_nxt;
      sram_addr <= sram_addr_nxt;
      sram_d_oe <= sram_d_oe_nxt;
      sram_ce_n <= ce_n_nxt;
      sram_oe_n <= oe_n_nxt;
      sram_we_n <= we_n_nxt;
    end
  end

  // Latched request attributes and write data; only meaningful during an access.
  always_ff @(posedge clk) begin
    grant_dp   <= grant_dp_nxt;
    op_wr      <= op_wr_nxt;
    sram_d_out <= sram_d_out_nxt;
  end

  assign if_ack   = (state == ACK) & ~grant_dp;
  assign dp_ack   = (state == ACK) &  grant_dp;
  assign if_d_out = rd_data;
  assign dp_d_out = rd_data;

endmodule

// File: tb/tb_ifetch_sram_arbiter.sv
// Directed bench for ifetch_sram_arbiter: one instance with WAIT_STATES=1,
// one with WAIT_STATES=0, each attached to a behavioural async SRAM.
module tb_ifetch_sram_arbiter;

  typedef struct {
    bit         port;   // 0 = fetcher, 1 = data port
    bit         wr;
    logic [7:0] data;
  } exp_t;

  logic clk = 0, reset = 1;
  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  exp_t q1[$], q0[$];
  logic [7:0] mem1 [0:32767];
  logic [7:0] mem0 [0:32767];

  logic [14:0] if_addr1 = '0, dp_addr1 = '0, sram_addr1;
  logic        if_rd_en1 = 0, dp_rd_en1 = 0, dp_wr_en1 = 0;
  logic [7:0]  dp_d_in1 = '0, if_d_out1, dp_d_out1, sram_d_out1, sram_d_in1;
  logic        if_ack1, dp_ack1, d_oe1, ce_n1, oe_n1, we_n1;

  logic [14:0] if_addr0 = '0, dp_addr0 = '0, sram_addr0;
  logic        if_rd_en0 = 0, dp_rd_en0 = 0, dp_wr_en0 = 0;
  logic [7:0]  dp_d_in0 = '0, if_d_out0, dp_d_out0, sram_d_out0, sram_d_in0;
  logic        if_ack0, dp_ack0, d_oe0, ce_n0, oe_n0, we_n0;

  ifetch_sram_arbiter #(.SRAM_ADDR_SIZE(15), .DATA_SIZE(8), .WAIT_STATES(1)) dut1 (
    .clk(clk), .reset(reset),
    .if_addr(if_addr1), .if_rd_en(if_rd_en1), .if_ack(if_ack1), .if_d_out(if_d_out1),
    .dp_addr(dp_addr1), .dp_rd_en(dp_rd_en1), .dp_wr_en(dp_wr_en1), .dp_d_in(dp_d_in1),
    .dp_ack(dp_ack1), .dp_d_out(dp_d_out1),
    .sram_addr(sram_addr1), .sram_d_out(sram_d_out1), .sram_d_oe(d_oe1), .sram_d_in(sram_d_in1),
    .sram_ce_n(ce_n1), .sram_oe_n(oe_n1), .sram_we_n(we_n1));

  ifetch_sram_arbiter #(.SRAM_ADDR_SIZE(15), .DATA_SIZE(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset),
    .if_addr(if_addr0), .if_rd_en(if_rd_en0), .if_ack(if_ack0), .if_d_out(if_d_out0),
    .dp_addr(dp_addr0), .dp_rd_en(dp_rd_en0), .dp_wr_en(dp_wr_en0), .dp_d_in(dp_d_in0),
    .dp_ack(dp_ack0), .dp_d_out(dp_d_out0),
    .sram_addr(sram_addr0), .sram_d_out(sram_d_out0), .sram_d_oe(d_oe0), .sram_d_in(sram_d_in0),
    .sram_ce_n(ce_n0), .sram_oe_n(oe_n0), .sram_we_n(we_n0));

  // Async SRAM models: read data only while selected and output-enabled.
  assign sram_d_in1 = (!ce_n1 && !oe_n1) ? mem1[sram_addr1] : 8'hEE;
  assign sram_d_in0 = (!ce_n0 && !oe_n0) ? mem0[sram_addr0] : 8'hEE;
  always @(negedge clk) if (!ce_n1 && !we_n1 && d_oe1) mem1[sram_addr1] <= sram_d_out1;
  always @(negedge clk) if (!ce_n0 && !we_n0 && d_oe0) mem0[sram_addr0] <= sram_d_out0;

  function automatic logic [7:0] pat(int a);
    return 8'(a * 37 + 11);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (if_ack1 | dp_ack1) begin
      chk("dual_ack1", {31'd0, if_ack1 & dp_ack1}, 0);
      chk("sb1_pending", {31'd0, q1.size() > 0}, 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("sb1_port", {31'd0, dp_ack1}, {31'd0, e.port});
        if (!e.wr) chk("sb1_data", e.port ? dp_d_out1 : if_d_out1, e.data);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if_ack0 | dp_ack0) begin
      chk("dual_ack0", {31'd0, if_ack0 & dp_ack0}, 0);
      chk("sb0_pending", {31'd0, q0.size() > 0}, 1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("sb0_port", {31'd0, dp_ack0}, {31'd0, e.port});
        if (!e.wr) chk("sb0_data", e.port ? dp_d_out0 : if_d_out0, e.data);
      end
    end
  end

  // Wait for the next ack on the selected instance, counting cycles and strobe activity.
  task automatic wait_ack(input bit sel, output int n, output int we_lo, output int doe);
    bit got;
    n = 0; we_lo = 0; doe = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (sel) begin
        if (!we_n1) we_lo++;
        if (d_oe1) doe++;
        got = if_ack1 | dp_ack1;
      end else begin
        if (!we_n0) we_lo++;
        if (d_oe0) doe++;
        got = if_ack0 | dp_ack0;
      end
    end
    chk("ack_timeout", {31'd0, got}, 1);
  endtask

  initial begin
    int n, wl, doe;
    for (int i = 0; i < 32768; i++) begin
      mem1[i] = pat(i);
      mem0[i] = pat(i);
    end
    mem1[15'h1005] = 8'hA7;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_if_ack", {31'd0, if_ack1}, 0);
    chk("rst_dp_ack", {31'd0, dp_ack1}, 0);
    chk("rst_rd_data", {24'd0, if_d_out1}, 0);
    chk("rst_addr", {17'd0, sram_addr1}, 0);
    chk("rst_strobes", {28'd0, d_oe1, ce_n1, oe_n1, we_n1}, 32'h7);
    chk("rst_strobes0", {28'd0, d_oe0, ce_n0, oe_n0, we_n0}, 32'h7);
    reset = 0;
    @(negedge clk);

    // 1: fetcher read
    if_addr1 = 15'h1005; if_rd_en1 = 1; q1.push_back('{0, 0, 8'hA7});
    wait_ack(1, n, wl, doe);
    chk("t1_latency", n, 3);
    chk("t1_data", {24'd0, if_d_out1}, 32'hA7);
    if_rd_en1 = 0;
    @(negedge clk);
    chk("t1_single_pulse", {31'd0, if_ack1}, 0);

    // 2: data-port write, then read back
    dp_addr1 = 15'h2010; dp_d_in1 = 8'h5C; dp_wr_en1 = 1; q1.push_back('{1, 1, 8'h00});
    wait_ack(1, n, wl, doe);
    chk("t2_we_cycles", wl, 2);
    chk("t2_doe_cycles", doe, 3);
    chk("t2_rd_data_kept", {24'd0, dp_d_out1}, 32'hA7);
    dp_wr_en1 = 0;
    @(negedge clk);
    chk("t2_mem", {24'd0, mem1[15'h2010]}, 32'h5C);
    chk("t2_doe_off", {31'd0, d_oe1}, 0);
    dp_rd_en1 = 1; q1.push_back('{1, 0, 8'h5C});
    wait_ack(1, n, wl, doe);
    chk("t2_rd_latency", n, 3);
    dp_rd_en1 = 0;
    @(negedge clk);

    // 3: simultaneous requests alternate
    if_addr1 = 15'h0100; dp_addr1 = 15'h0200; if_rd_en1 = 1; dp_rd_en1 = 1;
    for (int k = 0; k < 4; k++) q1.push_back('{k[0], 0, k[0] ? pat(15'h0200) : pat(15'h0100)});
    for (int k = 0; k < 4; k++) begin
      wait_ack(1, n, wl, doe);
      chk("t3_spacing", n, (k == 0) ? 3 : 4);
    end
    if_rd_en1 = 0; dp_rd_en1 = 0;
    @(negedge clk);

    // 4: fetcher streams addresses 0..3 with rd_en held
    if_addr1 = 15'h0000; if_rd_en1 = 1; q1.push_back('{0, 0, pat(0)});
    for (int k = 0; k < 4; k++) begin
      wait_ack(1, n, wl, doe);
      chk("t4_spacing", n, (k == 0) ? 3 : 4);
      if (k < 3) begin
        if_addr1 = 15'(k + 1);
        q1.push_back('{0, 0, pat(k + 1)});
      end else begin
        if_rd_en1 = 0;
      end
    end
    repeat (8) @(negedge clk);
    chk("t4_drained", q1.size(), 0);

    // 5: reset during the access phase of a write
    dp_addr1 = 15'h0300; dp_d_in1 = 8'h11; dp_wr_en1 = 1;
    @(negedge clk);
    chk("t5_we_active", {31'd0, we_n1}, 0);
    reset = 1;
    @(negedge clk);
    chk("t5_abort_strobes", {28'd0, d_oe1, ce_n1, oe_n1, we_n1}, 32'h7);
    chk("t5_no_ack", {30'd0, if_ack1, dp_ack1}, 0);
    reset = 0; dp_wr_en1 = 0;
    repeat (4) @(negedge clk);
    if_addr1 = 15'h1005; if_rd_en1 = 1; q1.push_back('{0, 0, 8'hA7});
    wait_ack(1, n, wl, doe);
    chk("t5_recover_latency", n, 3);
    if_rd_en1 = 0;
    @(negedge clk);

    // 6: zero wait states, read then combined read+write on the data port
    dp_addr0 = 15'h0050; dp_rd_en0 = 1; q0.push_back('{1, 0, pat(15'h0050)});
    wait_ack(0, n, wl, doe);
    chk("t6_rd_latency", n, 2);
    dp_rd_en0 = 0;
    @(negedge clk);
    dp_addr0 = 15'h0040; dp_d_in0 = 8'h3C; dp_rd_en0 = 1; dp_wr_en0 = 1;
    q0.push_back('{1, 1, 8'h00});
    wait_ack(0, n, wl, doe);
    chk("t6_wr_latency", n, 2);
    chk("t6_we_cycles", wl, 1);
    chk("t6_rd_data_kept", {24'd0, dp_d_out0}, {24'd0, pat(15'h0050)});
    dp_rd_en0 = 0; dp_wr_en0 = 0;
    @(negedge clk);
    chk("t6_mem", {24'd0, mem0[15'h0040]}, 32'h3C);
    repeat (4) @(negedge clk);
    chk("t6_drained", q0.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
